// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite register slave.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    localparam int unsigned NUM_REGS = 4;

    localparam logic [3:0] REG_ADDR_0 = 4'h0;
    localparam logic [3:0] REG_ADDR_1 = 4'h4;
    localparam logic [3:0] REG_ADDR_2 = 4'h8;
    localparam logic [3:0] REG_ADDR_3 = 4'hC;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Four 32-bit software registers: byte-strobed write port, combinational read, flat export.
module axi_lite_reg_bank
    import axi_lite_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [1:0]               widx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic [1:0]               ridx,
    output logic [31:0]              rdata,
    output logic [NUM_REGS*32-1:0]   reg_q
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write value when a commit lands on the same edge.
    assign rdata = regs_q[ridx];

    always_comb begin
        reg_q = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            reg_q[32*k +: 32] = regs_q[k];
        end
    end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave exposing four 32-bit registers; AW and W are accepted independently
// and held until both are present, then committed with a single B response.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      A_CLK,
    input  logic                      A_RESET,
    input  logic [ADDR_WIDTH-1:0]     AW_ADDR,
    input  logic                      AW_VALID,
    output logic                      AW_READY,
    input  logic [DATA_WIDTH-1:0]     W_DATA,
    input  logic [DATA_WIDTH/8-1:0]   W_STRB,
    input  logic                      W_VALID,
    output logic                      W_READY,
    output logic [1:0]                B_RESP,
    output logic                      B_VALID,
    input  logic                      B_READY,
    input  logic [ADDR_WIDTH-1:0]     AR_ADDR,
    input  logic                      AR_VALID,
    output logic                      AR_READY,
    output logic [DATA_WIDTH-1:0]     R_DATA,
    output logic [1:0]                R_RESP,
    output logic                      R_VALID,
    input  logic                      R_READY,
    output logic [4*DATA_WIDTH-1:0]   REG_Q
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("axi_lite_reg_slave supports DATA_WIDTH == 32 only");
    end

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:4] == '0) && (a[1:0] == 2'b00);
    endfunction

    logic                    aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic                    w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic                    b_valid_q, b_valid_d;
    resp_t                   b_resp_q, b_resp_d;
    logic                    r_valid_q, r_valid_d;
    resp_t                   r_resp_q, r_resp_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;

    logic                    aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data, bank_rdata;
    logic [DATA_WIDTH/8-1:0] wr_strb;

    assign AW_READY = !aw_held_q && !b_valid_q;
    assign W_READY  = !w_held_q && !b_valid_q;
    assign AR_READY = !r_valid_q;

    assign aw_hs  = AW_VALID && AW_READY;
    assign w_hs   = W_VALID && W_READY;
    assign ar_hs  = AR_VALID && AR_READY;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // Held beats take priority; otherwise the beat handshaking this cycle is used directly.
    assign wr_addr = aw_held_q ? aw_addr_q : AW_ADDR;
    assign wr_data = w_held_q ? w_data_q : W_DATA;
    assign wr_strb = w_held_q ? w_strb_q : W_STRB;
    assign wr_ok   = addr_ok(wr_addr);
    assign rd_ok   = addr_ok(AR_ADDR);

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;

        if (b_valid_q && B_READY) begin
            b_valid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            if (wr_ok) b_resp_d = RESP_OKAY;
            else       b_resp_d = RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_addr_d = AW_ADDR;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = W_DATA;
                w_strb_d = W_STRB;
            end
        end

        if (ar_hs) begin
            r_valid_d = 1'b1;
            if (rd_ok) begin
                r_resp_d = RESP_OKAY;
                r_data_d = bank_rdata;
            end else begin
                r_resp_d = RESP_SLVERR;
                r_data_d = '0;
            end
        end else if (r_valid_q && R_READY) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge A_CLK or posedge A_RESET) begin
        if (A_RESET) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    assign B_VALID = b_valid_q;
    assign B_RESP  = b_resp_q;
    assign R_VALID = r_valid_q;
    assign R_RESP  = r_resp_q;
    assign R_DATA  = r_data_q;

    axi_lite_reg_bank u_bank (
        .clk   (A_CLK),
        .rst   (A_RESET),
        .we    (commit && wr_ok),
        .widx  (wr_addr[3:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .ridx  (AR_ADDR[3:2]),
        .rdata (bank_rdata),
        .reg_q (REG_Q)
    );

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the register file.
module tb_axi_lite_reg_slave;

    logic         A_CLK = 1'b0;
    logic         A_RESET;
    logic [31:0]  AW_ADDR, W_DATA, AR_ADDR, R_DATA;
    logic         AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic         AR_VALID, AR_READY, R_VALID, R_READY;
    logic [3:0]   W_STRB;
    logic [1:0]   B_RESP, R_RESP;
    logic [127:0] REG_Q;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 A_CLK = ~A_CLK;

    axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .A_CLK(A_CLK), .A_RESET(A_RESET),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
        .REG_Q(REG_Q)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [4];
    bit          m_aw_have, m_w_have, m_b_valid, m_r_valid;
    logic [31:0] m_aw_addr, m_w_data, m_r_data;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;

    function automatic bit m_ok(input logic [31:0] a);
        return (a < 32'd16) && (a % 4 == 0);
    endfunction

    always @(posedge A_CLK or posedge A_RESET) begin
        bit aw_take, w_take, ar_take;
        logic [31:0] cur;
        if (A_RESET) begin
            for (int k = 0; k < 4; k++) mregs[k] = 32'h0;
            m_aw_have = 0; m_w_have = 0; m_b_valid = 0; m_r_valid = 0;
            m_aw_addr = 0; m_w_data = 0; m_w_strb = 0;
            m_b_resp = 0; m_r_resp = 0; m_r_data = 0;
        end else begin
            aw_take = AW_VALID && !m_aw_have && !m_b_valid;
            w_take  = W_VALID && !m_w_have && !m_b_valid;
            ar_take = AR_VALID && !m_r_valid;
            if (ar_take) begin
                m_r_valid = 1;
                m_r_resp  = m_ok(AR_ADDR) ? 2'b00 : 2'b10;
                m_r_data  = m_ok(AR_ADDR) ? mregs[AR_ADDR / 4] : 32'h0;
            end else if (m_r_valid && R_READY) begin
                m_r_valid = 0;
            end
            if (m_b_valid && B_READY) m_b_valid = 0;
            if (aw_take) begin m_aw_have = 1; m_aw_addr = AW_ADDR; end
            if (w_take)  begin m_w_have = 1; m_w_data = W_DATA; m_w_strb = W_STRB; end
            if (m_aw_have && m_w_have) begin
                if (m_ok(m_aw_addr)) begin
                    cur = mregs[m_aw_addr / 4];
                    for (int b = 0; b < 4; b++)
                        if (m_w_strb[b]) cur[8*b +: 8] = m_w_data[8*b +: 8];
                    mregs[m_aw_addr / 4] = cur;
                    m_b_resp = 2'b00;
                end else begin
                    m_b_resp = 2'b10;
                end
                m_b_valid = 1; m_aw_have = 0; m_w_have = 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare_all();
        chk("aw_ready", AW_READY, !m_aw_have && !m_b_valid);
        chk("w_ready",  W_READY,  !m_w_have && !m_b_valid);
        chk("ar_ready", AR_READY, !m_r_valid);
        chk("b_valid",  B_VALID,  m_b_valid);
        chk("b_resp",   B_RESP,   m_b_resp);
        chk("r_valid",  R_VALID,  m_r_valid);
        chk("r_resp",   R_RESP,   m_r_resp);
        chk("r_data",   R_DATA,   m_r_data);
        chk("reg_q",    REG_Q,    {mregs[3], mregs[2], mregs[1], mregs[0]});
    endtask

    task automatic tick();
        @(posedge A_CLK);
        #1;
        compare_all();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        AR_ADDR = a; AR_VALID = 1; R_READY = 0;
        tick();
        n = 0;
        while (!R_VALID && n < 10) begin tick(); n++; end
        AR_VALID = 0;
        chk("rd_valid", R_VALID, 1'b1);
        chk("rd_data", R_DATA, ed);
        chk("rd_resp", R_RESP, er);
        R_READY = 1;
        tick();
        R_READY = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input logic [1:0] er);
        AW_ADDR = a; W_DATA = d; W_STRB = s; B_READY = 0;
        if (lead > 0) begin
            W_VALID = 1;
            tick();
            W_VALID = 0;
            for (int i = 0; i < lead - 1; i++) begin
                tick();
                chk("wr_early_bvalid", B_VALID, 1'b0);
            end
        end else begin
            W_VALID = 1;
        end
        AW_VALID = 1;
        tick();
        AW_VALID = 0; W_VALID = 0;
        chk("wr_bvalid_latency", B_VALID, 1'b1);
        chk("wr_bresp", B_RESP, er);
        B_READY = 1;
        tick();
        B_READY = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom % 8)
            0: return 32'h00;
            1: return 32'h04;
            2: return 32'h08;
            3: return 32'h0C;
            4: return 32'h10;
            5: return 32'h02;
            6: return 32'h14;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        A_RESET = 1;
        AW_ADDR = 0; AW_VALID = 0; W_DATA = 0; W_STRB = 0; W_VALID = 0; B_READY = 0;
        AR_ADDR = 0; AR_VALID = 0; R_READY = 0;
        tick(); tick();
        A_RESET = 0;
        tick();
        chk("reset_regq", REG_Q, 128'h0);
        chk("reset_ready", {AW_READY, W_READY, AR_READY}, 3'b111);

        for (int k = 0; k < 4; k++) do_read(32'(k * 4), 32'h0, 2'b00);

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 2'b00);
        do_read(32'h04, 32'hDEADBEEF, 2'b00);

        do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 2'b00);
        do_write(32'h08, 32'h11223344, 4'b0101, 3, 2'b00);
        do_read(32'h08, 32'hFF22FF44, 2'b00);

        do_write(32'h10, 32'h55555555, 4'hF, 0, 2'b10);
        do_write(32'h02, 32'h66666666, 4'hF, 1, 2'b10);
        chk("slverr_no_change", REG_Q, {32'h0, 32'hFF22FF44, 32'hDEADBEEF, 32'h0});
        do_read(32'h14, 32'h0, 2'b10);
        do_write(32'h04, 32'h12345678, 4'h0, 0, 2'b00);
        chk("zero_strb", REG_Q[63:32], 32'hDEADBEEF);

        // write response held off while a read proceeds
        AW_ADDR = 32'h0C; W_DATA = 32'hCAFEF00D; W_STRB = 4'hF;
        AW_VALID = 1; W_VALID = 1; B_READY = 0;
        tick();
        AW_VALID = 0; W_VALID = 0;
        AR_ADDR = 32'h0C; AR_VALID = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bhold_valid", B_VALID, 1'b1);
            chk("bhold_resp", B_RESP, 2'b00);
            chk("bhold_ready", {AW_READY, W_READY}, 2'b00);
            if (i == 0) begin
                chk("bhold_rd_valid", R_VALID, 1'b1);
                chk("bhold_rd_data", R_DATA, 32'hCAFEF00D);
                AR_VALID = 0; R_READY = 1;
            end else if (i == 1) begin
                chk("bhold_rd_done", R_VALID, 1'b0);
                R_READY = 0;
            end
        end
        B_READY = 1;
        tick();
        B_READY = 0;
        chk("bhold_release", B_VALID, 1'b0);

        // asynchronous reset with both responses pending
        AW_ADDR = 32'h00; W_DATA = 32'h12345678; W_STRB = 4'hF; AW_VALID = 1; W_VALID = 1;
        AR_ADDR = 32'h04; AR_VALID = 1;
        tick();
        AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
        chk("pre_rst_valids", {B_VALID, R_VALID}, 2'b11);
        chk("pre_rst_rdata", R_DATA, 32'hDEADBEEF);
        chk("pre_rst_regq", REG_Q, {32'hCAFEF00D, 32'hFF22FF44, 32'hDEADBEEF, 32'h12345678});
        A_RESET = 1;
        #1;
        chk("async_rst_valids", {B_VALID, R_VALID}, 2'b00);
        chk("async_rst_regq", REG_Q, 128'h0);
        compare_all();
        tick(); tick();
        A_RESET = 0;
        tick();
        chk("post_rst_ready", {AW_READY, W_READY, AR_READY}, 3'b111);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            AW_VALID = ($urandom % 3) == 0;
            AW_ADDR  = pick_addr();
            W_VALID  = ($urandom % 3) == 0;
            W_DATA   = $urandom;
            W_STRB   = 4'($urandom);
            B_READY  = ($urandom % 2) == 0;
            AR_VALID = ($urandom % 2) == 0;
            AR_ADDR  = pick_addr();
            R_READY  = ($urandom % 2) == 0;
            A_RESET  = ($urandom % 500) == 0;
            tick();
        end
        A_RESET = 0; AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
Name:
axi_lite_reg_slave

Overview:
AXI-Lite slave endpoint that sits directly downstream of the AXI-Lite bus interface and consumes its DUT-side signals. It implements four 32-bit software registers at byte offsets 0x00/0x04/0x08/0x0C, with per-byte write strobes and OKAY/SLVERR responses. It also exports the live register contents to the peripheral logic.

Parameters:
ADDR_WIDTH, 32, byte-address width of AW_ADDR/AR_ADDR.
DATA_WIDTH, 32, data width; only 32 is supported, and elaboration fails on any other value.

Ports:
A_CLK  in  1  single clock; all state updates on its rising edge
A_RESET  in  1  asynchronous, active-high reset
AW_ADDR  in  ADDR_WIDTH  write address
AW_VALID  in  1  write address valid
AW_READY  out  1  write address ready
W_DATA  in  DATA_WIDTH  write data
W_STRB  in  DATA_WIDTH/8  byte write enables; bit i covers W_DATA[8i+7:8i]
W_VALID  in  1  write data valid
W_READY  out  1  write data ready
B_RESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
B_VALID  out  1  write response valid
B_READY  in  1  write response ready
AR_ADDR  in  ADDR_WIDTH  read address
AR_VALID  in  1  read address valid
AR_READY  out  1  read address ready
R_DATA  out  DATA_WIDTH  read data
R_RESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
R_VALID  out  1  read data valid
R_READY  in  1  read data ready
REG_Q  out  4*DATA_WIDTH  register contents; REG_Q[32k+31:32k] is register k, registered, no added latency

Behaviour:
- Reset (A_RESET=1, asynchronous, any cycle including mid-transaction): all registers 0; B_VALID, R_VALID, B_RESP, R_RESP, R_DATA = 0; AW/W held flags cleared; any in-flight transaction is dropped.
- Ready signals: AW_READY = !aw_held && !B_VALID; W_READY = !w_held && !B_VALID; AR_READY = !R_VALID. All are combinational from registered state only, never from VALID inputs.
- Address decode: a valid address has addr[ADDR_WIDTH-1:4]==0 and addr[1:0]==0; the register index is addr[3:2]. Any other address is an error.
- Write channel: AW and W are accepted independently in either order or in the same cycle. The accepted address/data/strobe are latched into held flags and registers.
- Write commit edge: the first edge where (aw_held||AW handshake) && (w_held||W handshake). At that edge:
  - valid address: reg[idx] bytes with W_STRB=1 are updated, others keep their value; B_RESP=OKAY.
  - error address: no register change; B_RESP=SLVERR.
  - B_VALID=1 and both held flags clear.
- Write latency: B_VALID is visible the cycle after the later of the AW/W handshakes. The new register value is visible on REG_Q and to reads in the same cycle.
- B_VALID/B_RESP stay stable until the B_READY handshake; B_VALID=0 the next cycle. At most one write is outstanding.
- W_STRB=0 on a valid address: no change, OKAY.
- Read: on the AR handshake edge, R_VALID=1. R_DATA = reg[idx] with R_RESP=OKAY, or R_DATA=0 with R_RESP=SLVERR for an error address.
- R_DATA/R_RESP stay stable until the R_READY handshake. Maximum read throughput is 1 per 2 cycles.
- Same-edge read and write-commit to the same register: the read returns the pre-write value.
- Read and write channels are fully independent; neither blocks the other.

Decomposition:
- Package axi_lite_pkg: resp_t enum (RESP_OKAY=2'b00, RESP_SLVERR=2'b10); NUM_REGS=4; REG_ADDR_0..3 = 'h00/'h04/'h08/'h0C.
- One sub-module, axi_lite_reg_bank: 4x32 register array with a strobe-merge write port, combinational read by index, and the REG_Q export.

Test Plan:
- Reset, then read 0x00..0x0C -> R_DATA=0 and R_RESP=OKAY for each; REG_Q=0.
- Write 0x04 = 0xDEADBEEF with W_STRB=4'hF, AW and W in the same cycle -> B_VALID the next cycle, B_RESP=OKAY; read 0x04 -> 0xDEADBEEF.
- W arrives 3 cycles before AW, writing 0x08 = 0x11223344 with W_STRB=4'b0101 over 0xFFFFFFFF -> reg2=0xFF22FF44; B_VALID the cycle after the AW handshake.
- Write 0x10 and then 0x02 -> both return B_RESP=SLVERR with no register change; read 0x14 -> R_RESP=SLVERR, R_DATA=0.
- Hold B_READY=0 for 5 cycles -> B_VALID/B_RESP stable and AW_READY/W_READY low; a read of 0x0C issued concurrently completes normally.
- Assert A_RESET while B_VALID=1 and R_VALID=1 -> both outputs drop immediately, registers=0, and the ready signals return high after reset release.
